input_unit_vc: RTL and testbench

- Parametrised next-generation router input unit: VC_NUM virtual channels, each a FIFO of BUFFER_DEPTH flits with its own per-VC state machine.
- Per-VC flow: routing (XY) -> VC allocation -> switch allocation.
- Credit-based flow control replaces on/off: one credit returns upstream per flit dequeued.
- Sits between the upstream link and the VC/switch allocators and crossbar of one router port; flat ports only.

---
 rtl/input_unit_vc.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_input_unit_vc.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_unit_vc.sv
// -----------------------------------------------------------------------------
// input_unit_vc
//
// Router input unit for one port. Incoming flits are steered into one of
// VC_NUM per-VC FIFOs. Each VC walks IDLE -> RC (XY route) -> VA (VC
// allocation) -> ACTIVE (switch allocation, one flit per grant). A TAIL or
// HEADTAIL leaving the FIFO returns the VC to IDLE. Every dequeued flit,
// forwarded or discarded, returns one credit upstream.
//
// Optional feature macro: INPUT_UNIT_ERR_CHECK_EN
//   defined   : err_o is a sticky protocol-error flag (cleared by rst only)
//   undefined : err_o is tied to 0 and no check logic exists
//
// Handshakes: va_req_o[v] is held while VC v waits in VA; a va_grant_i[v]
// seen in that cycle is accepted at the clock edge. sa_req_o[v] is high
// while VC v is ACTIVE with a flit at its FIFO front; an sa_grant_i[v] seen
// in that cycle pops exactly that flit (lowest requesting index wins when
// the grant is multi-hot). Grants to non-requesting VCs have no effect.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_i, flit_type_i,
//   vc_id_i, x_dest_i,
//   y_dest_i, payload_i      upstream flit (type 0=HEAD 1=BODY 2=TAIL 3=HEADTAIL)
//   credit_o[VC_NUM]         one-cycle credit pulse per dequeued flit
//   va_req_o, out_port_o     VC allocation request and routed port per VC
//   va_grant_i, va_vc_i      VC allocation grant and downstream VC
//   sa_req_o, sa_grant_i     switch allocation request / grant
//   flit_valid_o, flit_type_o,
//   flit_vc_o, payload_o     registered crossbar flit
//   err_o                    sticky error flag (optional feature)
// -----------------------------------------------------------------------------
module input_unit_vc #(
   parameter int VC_NUM       = 4,
   parameter int BUFFER_DEPTH = 8,
   parameter int PAYLOAD_W    = 32,
   parameter int COORD_W      = 3,
   parameter int X_CURRENT    = 2,
   parameter int Y_CURRENT    = 2,
   localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_i,
   input  logic [1:0]              flit_type_i,
   input  logic [VC_W-1:0]         vc_id_i,
   input  logic [COORD_W-1:0]      x_dest_i,
   input  logic [COORD_W-1:0]      y_dest_i,
   input  logic [PAYLOAD_W-1:0]    payload_i,
   output logic [VC_NUM-1:0]       credit_o,
   output logic [VC_NUM-1:0]       va_req_o,
   output logic [3*VC_NUM-1:0]     out_port_o,
   input  logic [VC_NUM-1:0]       va_grant_i,
   input  logic [VC_W*VC_NUM-1:0]  va_vc_i,
   output logic [VC_NUM-1:0]       sa_req_o,
   input  logic [VC_NUM-1:0]       sa_grant_i,
   output logic                    flit_valid_o,
   output logic [1:0]              flit_type_o,
   output logic [VC_W-1:0]         flit_vc_o,
   output logic [PAYLOAD_W-1:0]    payload_o,
   output logic                    err_o
);

   localparam int PTR_W   = $clog2(BUFFER_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 2 + 2*COORD_W + PAYLOAD_W;

   localparam logic [1:0] FT_HEAD     = 2'd0;
   localparam logic [1:0] FT_BODY     = 2'd1;
   localparam logic [1:0] FT_TAIL     = 2'd2;
   localparam logic [1:0] FT_HEADTAIL = 2'd3;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_SOUTH = 3'd2;
   localparam logic [2:0] PORT_WEST  = 3'd3;
   localparam logic [2:0] PORT_EAST  = 3'd4;

   typedef enum logic [1:0] {
      VC_IDLE   = 2'd0,
      VC_RC     = 2'd1,
      VC_VA     = 2'd2,
      VC_ACTIVE = 2'd3
   } vc_state_e;

   // Per-VC state: state_q is the FSM state array checkers can bind to.
   vc_state_e          state_q    [VC_NUM];
   vc_state_e          state_d    [VC_NUM];
   logic [PTR_W-1:0]   wr_ptr_q   [VC_NUM];
   logic [PTR_W-1:0]   rd_ptr_q   [VC_NUM];
   logic [CNT_W-1:0]   count_q    [VC_NUM];
   logic [2:0]         out_port_q [VC_NUM];
   logic [VC_W-1:0]    dvc_q      [VC_NUM];
   logic [ENTRY_W-1:0] mem_q      [VC_NUM][BUFFER_DEPTH];

   // FIFO front decode
   logic [1:0]           front_type [VC_NUM];
   logic [COORD_W-1:0]   front_x    [VC_NUM];
   logic [COORD_W-1:0]   front_y    [VC_NUM];
   logic [PAYLOAD_W-1:0] front_pl   [VC_NUM];
   logic [2:0]           rc_port    [VC_NUM];

   logic [VC_NUM-1:0] empty;
   logic [VC_NUM-1:0] full;
   logic [VC_NUM-1:0] wr_en;
   logic [VC_NUM-1:0] sa_hit;
   logic [VC_NUM-1:0] sa_pop;
   logic [VC_NUM-1:0] discard;
   logic [VC_NUM-1:0] pop;

   logic                 sel_found;
   logic [1:0]           sel_type;
   logic [PAYLOAD_W-1:0] sel_pl;
   logic [VC_W-1:0]      sel_dvc;

   // Output registers
   logic                 flit_valid_q;
   logic [1:0]           flit_type_q;
   logic [VC_W-1:0]      flit_vc_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [VC_NUM-1:0]    credit_q;

   function automatic logic is_head(input logic [1:0] t);
      return (t == FT_HEAD) || (t == FT_HEADTAIL);
   endfunction

   function automatic logic is_tail(input logic [1:0] t);
      return (t == FT_TAIL) || (t == FT_HEADTAIL);
   endfunction

   // Dimension-ordered routing: resolve X first, then Y.
   function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
      logic [2:0] p;
      p = PORT_LOCAL;
      if (x > COORD_W'(X_CURRENT))      p = PORT_EAST;
      else if (x < COORD_W'(X_CURRENT)) p = PORT_WEST;
      else if (y > COORD_W'(Y_CURRENT)) p = PORT_SOUTH;
      else if (y < COORD_W'(Y_CURRENT)) p = PORT_NORTH;
      return p;
   endfunction

   // ---------------------------------------------------------------------------
   // FIFO status, write steering and front decode
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         empty[v] = (count_q[v] == '0);
         // Full is judged on the registered count, so a same-cycle pop
         // never makes room for a write.
         full[v]  = (count_q[v] == CNT_W'(BUFFER_DEPTH));
         wr_en[v] = valid_i && (vc_id_i == VC_W'(v)) && !full[v];
         {front_type[v], front_x[v], front_y[v], front_pl[v]} = mem_q[v][rd_ptr_q[v]];
         rc_port[v] = xy_route(front_x[v], front_y[v]);
      end
   end

   // ---------------------------------------------------------------------------
   // Requests, switch grant qualification and pops
   // ---------------------------------------------------------------------------
   always_comb begin
      va_req_o  = '0;
      sa_req_o  = '0;
      sa_hit    = '0;
      sa_pop    = '0;
      discard   = '0;
      sel_found = 1'b0;
      sel_type  = '0;
      sel_pl    = '0;
      sel_dvc   = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         va_req_o[v] = (state_q[v] == VC_VA);
         sa_req_o[v] = (state_q[v] == VC_ACTIVE) && !empty[v];
         sa_hit[v]   = sa_grant_i[v] && sa_req_o[v];
         // Stray BODY/TAIL without a preceding HEAD is dropped in IDLE.
         discard[v]  = (state_q[v] == VC_IDLE) && !empty[v] &&
                       ((front_type[v] == FT_BODY) || (front_type[v] == FT_TAIL));
      end
      // Only one flit can cross the switch per cycle: serve lowest index.
      for (int v = 0; v < VC_NUM; v++) begin
         if (sa_hit[v] && !sel_found) begin
            sel_found = 1'b1;
            sa_pop[v] = 1'b1;
            sel_type  = front_type[v];
            sel_pl    = front_pl[v];
            sel_dvc   = dvc_q[v];
         end
      end
   end

   assign pop = sa_pop | discard;

   // ---------------------------------------------------------------------------
   // Per-VC FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
         case (state_q[v])
            VC_IDLE: begin
               if (!empty[v] && is_head(front_type[v])) state_d[v] = VC_RC;
            end
            VC_RC: begin
               state_d[v] = VC_VA;
            end
            VC_VA: begin
               if (va_grant_i[v]) state_d[v] = VC_ACTIVE;
            end
            VC_ACTIVE: begin
               if (sa_pop[v] && is_tail(front_type[v])) state_d[v] = VC_IDLE;
            end
            default: begin
               state_d[v] = VC_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Per-VC registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v]    <= VC_IDLE;
            wr_ptr_q[v]   <= '0;
            rd_ptr_q[v]   <= '0;
            count_q[v]    <= '0;
            out_port_q[v] <= PORT_LOCAL;
            dvc_q[v]      <= '0;
         end
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v] <= state_d[v];
            if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
            if (pop[v])   rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
            case ({wr_en[v], pop[v]})
               2'b10:   count_q[v] <= count_q[v] + CNT_W'(1);
               2'b01:   count_q[v] <= count_q[v] - CNT_W'(1);
               default: count_q[v] <= count_q[v];
            endcase
            // Route is captured once per packet and held afterwards.
            if (state_q[v] == VC_RC) out_port_q[v] <= rc_port[v];
            if ((state_q[v] == VC_VA) && va_grant_i[v])
               dvc_q[v] <= va_vc_i[v*VC_W +: VC_W];
         end
      end
   end

   // Flit storage carries no reset: contents are only read behind count_q.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_en[v])
            mem_q[v][wr_ptr_q[v]] <= {flit_type_i, x_dest_i, y_dest_i, payload_i};
      end
   end

   // ---------------------------------------------------------------------------
   // Crossbar output and credit return
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_valid_q <= 1'b0;
         flit_type_q  <= '0;
         flit_vc_q    <= '0;
         payload_q    <= '0;
         credit_q     <= '0;
      end else begin
         flit_valid_q <= sel_found;
         if (sel_found) begin
            flit_type_q <= sel_type;
            flit_vc_q   <= sel_dvc;
            payload_q   <= sel_pl;
         end
         credit_q <= pop;
      end
   end

   assign flit_valid_o = flit_valid_q;
   assign flit_type_o  = flit_type_q;
   assign flit_vc_o    = flit_vc_q;
   assign payload_o    = payload_q;
   assign credit_o     = credit_q;

   always_comb begin
      out_port_o = '0;
      for (int v = 0; v < VC_NUM; v++) out_port_o[3*v +: 3] = out_port_q[v];
   end

   // ---------------------------------------------------------------------------
   // Optional protocol error flag
   // ---------------------------------------------------------------------------
`ifdef INPUT_UNIT_ERR_CHECK_EN
   logic              err_q;
   logic [VC_NUM-1:0] started_q;   // a non-tail flit of the packet has left
   logic [VC_NUM-1:0] wr_drop;
   logic [VC_NUM-1:0] early_head;

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         wr_drop[v]    = valid_i && (vc_id_i == VC_W'(v)) && full[v];
         // A HEAD at the front while a packet is mid-flight means the
         // previous packet lost its TAIL.
         early_head[v] = (state_q[v] == VC_ACTIVE) && !empty[v] &&
                         is_head(front_type[v]) && started_q[v];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q     <= 1'b0;
         started_q <= '0;
      end else begin
         if (|wr_drop || |discard || |early_head) err_q <= 1'b1;
         for (int v = 0; v < VC_NUM; v++) begin
            if (sa_pop[v]) started_q[v] <= !is_tail(front_type[v]);
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_unit_vc.sv
// -----------------------------------------------------------------------------
// tb_input_unit_vc : directed bench for input_unit_vc (default parameters).
// A transaction model keeps per-VC FIFO contents, the latched downstream VC
// and a timed expectation list of output flits and credits; a negedge
// compare process checks flit, credit and err outputs every cycle.
// -----------------------------------------------------------------------------
module tb_input_unit_vc;

   localparam int VC_NUM = 4;
   localparam int DEPTH  = 8;
   localparam int VC_W   = 2;

`ifdef INPUT_UNIT_ERR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HT = 2'd3;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUT
   logic                   valid_i = 1'b0;
   logic [1:0]             flit_type_i = '0;
   logic [VC_W-1:0]        vc_id_i = '0;
   logic [2:0]             x_dest_i = '0;
   logic [2:0]             y_dest_i = '0;
   logic [31:0]            payload_i = '0;
   logic [VC_NUM-1:0]      credit_o;
   logic [VC_NUM-1:0]      va_req_o;
   logic [3*VC_NUM-1:0]    out_port_o;
   logic [VC_NUM-1:0]      va_grant_i = '0;
   logic [VC_W*VC_NUM-1:0] va_vc_i = '0;
   logic [VC_NUM-1:0]      sa_req_o;
   logic [VC_NUM-1:0]      sa_grant_i = '0;
   logic                   flit_valid_o;
   logic [1:0]             flit_type_o;
   logic [VC_W-1:0]        flit_vc_o;
   logic [31:0]            payload_o;
   logic                   err_o;

   input_unit_vc dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .flit_type_i  (flit_type_i),
      .vc_id_i      (vc_id_i),
      .x_dest_i     (x_dest_i),
      .y_dest_i     (y_dest_i),
      .payload_i    (payload_i),
      .credit_o     (credit_o),
      .va_req_o     (va_req_o),
      .out_port_o   (out_port_o),
      .va_grant_i   (va_grant_i),
      .va_vc_i      (va_vc_i),
      .sa_req_o     (sa_req_o),
      .sa_grant_i   (sa_grant_i),
      .flit_valid_o (flit_valid_o),
      .flit_type_o  (flit_type_o),
      .flit_vc_o    (flit_vc_o),
      .payload_o    (payload_o),
      .err_o        (err_o)
   );

   // ---------------------------------------------------------------- model
   typedef struct packed {
      logic [1:0]  t;
      logic [2:0]  x;
      logic [2:0]  y;
      logic [31:0] p;
   } flit_t;

   flit_t       m_q [VC_NUM][$];      // model FIFO contents per VC
   logic [1:0]  m_dvc [VC_NUM];       // downstream VC granted per VC
   logic [35:0] exp_q[$];             // {type, vc, payload}
   int          exp_due_q[$];
   int          cred_due_q[$];
   int          cred_vc_q[$];
   logic        exp_err = 1'b0;
   int          got_cred [VC_NUM];

   int checks = 0;
   int errors = 0;

   function automatic logic [2:0] route(input logic [2:0] x, input logic [2:0] y);
      if (x > 3'd2) return 3'd4;
      if (x < 3'd2) return 3'd3;
      if (y > 3'd2) return 3'd2;
      if (y < 3'd2) return 3'd1;
      return 3'd0;
   endfunction

   // ---------------------------------------------------------------- scoreboard
   always @(negedge clk) begin
      logic              exp_valid;
      logic [VC_NUM-1:0] exp_cred;
      if (!rst) begin
         exp_valid = (exp_q.size() > 0) && (exp_due_q[0] == cyc);
         checks++;
         if (flit_valid_o !== exp_valid) begin
            errors++;
            $display("FAIL flit_valid cyc=%0d: got %b expected %b", cyc, flit_valid_o, exp_valid);
         end else if (exp_valid) begin
            checks++;
            if ({flit_type_o, flit_vc_o, payload_o} !== exp_q[0]) begin
               errors++;
               $display("FAIL flit_data cyc=%0d: got 0x%0h expected 0x%0h",
                        cyc, {flit_type_o, flit_vc_o, payload_o}, exp_q[0]);
            end
         end
         if (exp_valid) begin
            void'(exp_q.pop_front());
            void'(exp_due_q.pop_front());
         end
         exp_cred = '0;
         for (int i = cred_due_q.size() - 1; i >= 0; i--) begin
            if (cred_due_q[i] == cyc) begin
               exp_cred[cred_vc_q[i]] = 1'b1;
               cred_due_q.delete(i);
               cred_vc_q.delete(i);
            end
         end
         checks++;
         if (credit_o !== exp_cred) begin
            errors++;
            $display("FAIL credit cyc=%0d: got %b expected %b", cyc, credit_o, exp_cred);
         end
         for (int v = 0; v < VC_NUM; v++) if (credit_o[v]) got_cred[v]++;
         checks++;
         if (err_o !== exp_err) begin
            errors++;
            $display("FAIL err_flag cyc=%0d: got %b expected %b", cyc, err_o, exp_err);
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_flit(input int v, input logic [1:0] t, input logic [2:0] x,
                             input logic [2:0] y, input logic [31:0] p);
      flit_t f;
      f = '{t: t, x: x, y: y, p: p};
      valid_i = 1'b1; flit_type_i = t; vc_id_i = VC_W'(v);
      x_dest_i = x; y_dest_i = y; payload_i = p;
      if (m_q[v].size() < DEPTH) m_q[v].push_back(f);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic do_va(input int v, input logic [1:0] dvc);
      int n;
      n = 0;
      while (!va_req_o[v] && n < 20) begin tick(); n++; end
      checks++;
      if (!va_req_o[v] || m_q[v].size() == 0) begin
         errors++;
         $display("FAIL va_req_timeout vc%0d: got 0 expected 1", v);
         return;
      end
      check($sformatf("out_port_vc%0d", v), out_port_o[3*v +: 3], route(m_q[v][0].x, m_q[v][0].y));
      va_grant_i[v] = 1'b1;
      va_vc_i[v*VC_W +: VC_W] = dvc;
      m_dvc[v] = dvc;
      tick();
      va_grant_i = '0;
      va_vc_i    = '0;
      check($sformatf("va_req_drop_vc%0d", v), va_req_o[v], 1'b0);
   endtask

   // Grant with an arbitrary mask; v is the VC the mask must serve.
   task automatic do_sa_mask(input logic [VC_NUM-1:0] mask, input int v);
      int    n;
      flit_t f;
      n = 0;
      while (!sa_req_o[v] && n < 20) begin tick(); n++; end
      checks++;
      if (!sa_req_o[v] || m_q[v].size() == 0) begin
         errors++;
         $display("FAIL sa_req_timeout vc%0d: got 0 expected 1", v);
         return;
      end
      sa_grant_i = mask;
      f = m_q[v].pop_front();
      exp_q.push_back({f.t, m_dvc[v], f.p});
      exp_due_q.push_back(cyc + 1);
      cred_due_q.push_back(cyc + 1);
      cred_vc_q.push_back(v);
      tick();
      sa_grant_i = '0;
   endtask

   task automatic do_sa(input int v);
      logic [VC_NUM-1:0] m;
      m = '0;
      m[v] = 1'b1;
      do_sa_mask(m, v);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flit_valid"}, flit_valid_o, 1'b0);
      check({tag, "_credit"},     credit_o, '0);
      check({tag, "_va_req"},     va_req_o, '0);
      check({tag, "_sa_req"},     sa_req_o, '0);
      check({tag, "_out_port"},   out_port_o, '0);
      check({tag, "_err"},        err_o, 1'b0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int k;
      for (int v = 0; v < VC_NUM; v++) begin got_cred[v] = 0; m_dvc[v] = '0; end

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      check("reset_flit_type", flit_type_o, 2'd0);
      check("reset_flit_vc",   flit_vc_o, 2'd0);
      check("reset_payload",   payload_o, 32'd0);
      rst = 1'b0;
      tick();

      // Single packet on VC0 to (3,2): EAST, downstream VC 2
      write_flit(0, HEAD, 3'd3, 3'd2, 32'hA0);
      write_flit(0, BODY, 3'd0, 3'd0, 32'hA1);
      write_flit(0, TAIL, 3'd0, 3'd0, 32'hA2);
      do_va(0, 2'd2);
      check("pkt_sa_req_after_va", sa_req_o[0], 1'b1);
      do_sa(0);
      check("pkt_head_out", {flit_valid_o, flit_type_o, flit_vc_o, payload_o},
            {1'b1, 2'd0, 2'd2, 32'hA0});
      do_sa(0);
      check("pkt_body_payload", payload_o, 32'hA1);
      do_sa(0);
      check("pkt_tail_out", {flit_type_o, flit_vc_o, payload_o}, {2'd2, 2'd2, 32'hA2});
      check("pkt_vc0_idle", {va_req_o[0], sa_req_o[0]}, 2'b00);
      check("pkt_port_hold", out_port_o[2:0], 3'd4);
      tick();
      check("pkt_credits_vc0", got_cred[0], 3);

      // HEADTAIL on VC1 to (2,2): LOCAL, VA request two cycles after write
      write_flit(1, HT, 3'd2, 3'd2, 32'hB0);
      check("ht_va_req_t0", va_req_o[1], 1'b0);
      tick();
      check("ht_va_req_t1", va_req_o[1], 1'b0);
      tick();
      check("ht_va_req_t2", va_req_o[1], 1'b1);
      do_va(1, 2'd1);
      do_sa(1);
      check("ht_out", {flit_type_o, flit_vc_o, payload_o}, {2'd3, 2'd1, 32'hB0});
      check("ht_vc1_idle", {va_req_o[1], sa_req_o[1]}, 2'b00);
      check("ht_port", out_port_o[5:3], 3'd0);

      // Stray BODY on idle VC0: dropped with a credit, no output flit
      k = cyc;
      write_flit(0, BODY, 3'd1, 3'd1, 32'hC0);
      void'(m_q[0].pop_back());
      cred_due_q.push_back(k + 2);
      cred_vc_q.push_back(0);
      tick();
      exp_err = ERR_EN;
      repeat (2) tick();
      check("discard_credits_vc0", got_cred[0], 4);
      check("discard_vc0_idle", {va_req_o[0], sa_req_o[0]}, 2'b00);

      // Reset in mid-packet: VC1 active with three stored flits
      write_flit(1, HEAD, 3'd1, 3'd2, 32'hE0);
      write_flit(1, BODY, 3'd0, 3'd0, 32'hE1);
      write_flit(1, BODY, 3'd0, 3'd0, 32'hE2);
      do_va(1, 2'd3);
      check("rst_pre_sa_req", sa_req_o[1], 1'b1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("midrst");
      for (int v = 0; v < VC_NUM; v++) m_q[v].delete();
      exp_q.delete(); exp_due_q.delete(); cred_due_q.delete(); cred_vc_q.delete();
      exp_err = 1'b0;
      k = got_cred[1];
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sa_grant_i = 4'b0010;
         va_grant_i = 4'b0010;
         tick();
      end
      sa_grant_i = '0;
      va_grant_i = '0;
      tick();
      check("rst_no_req_vc1", {va_req_o[1], sa_req_o[1]}, 2'b00);
      check("rst_no_credit_vc1", got_cred[1], k);

      // Full FIFO on VC2: ninth write dropped
      write_flit(2, HEAD, 3'd2, 3'd3, 32'hD0);
      for (int i = 1; i <= 6; i++) write_flit(2, BODY, 3'd0, 3'd0, 32'hD0 + i);
      write_flit(2, TAIL, 3'd0, 3'd0, 32'hD7);
      write_flit(2, HT, 3'd0, 3'd0, 32'hD8);
      exp_err = ERR_EN;
      check("full_model_depth", m_q[2].size(), DEPTH);
      k = got_cred[2];
      do_va(2, 2'd1);
      for (int i = 0; i < DEPTH; i++) do_sa(2);
      check("full_last_payload", payload_o, 32'hD7);
      tick();
      check("full_vc2_drained", {va_req_o[2], sa_req_o[2]}, 2'b00);
      check("full_credits_vc2", got_cred[2] - k, DEPTH);

      // Interleaved packets on VC0 (WEST) and VC3 (NORTH)
      write_flit(0, HEAD, 3'd0, 3'd2, 32'h10);
      write_flit(3, HEAD, 3'd2, 3'd0, 32'h30);
      write_flit(0, BODY, 3'd0, 3'd0, 32'h11);
      write_flit(3, BODY, 3'd0, 3'd0, 32'h31);
      write_flit(0, TAIL, 3'd0, 3'd0, 32'h12);
      write_flit(3, TAIL, 3'd0, 3'd0, 32'h32);
      do_va(0, 2'd3);
      do_va(3, 2'd0);
      check("il_both_req", {sa_req_o[3], sa_req_o[0]}, 2'b11);
      do_sa_mask(4'b1011, 0);   // multi-hot, VC1 idle: VC0 wins
      check("il_multihot_out", {flit_vc_o, payload_o}, {2'd3, 32'h10});
      check("il_vc3_still_req", sa_req_o[3], 1'b1);
      do_sa(3);
      check("il_vc3_head", {flit_vc_o, payload_o}, {2'd0, 32'h30});
      do_sa(0);
      do_sa(3);
      do_sa(0);
      do_sa(3);
      check("il_last", {flit_type_o, flit_vc_o, payload_o}, {2'd2, 2'd0, 32'h32});
      check("il_ports", {out_port_o[11:9], out_port_o[2:0]}, {3'd1, 3'd3});

      repeat (3) tick();
      check("exp_queue_drained", exp_q.size() + cred_due_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
